// File: rtl/mem_bus_responder_if.sv
// Control/status half of the external memory bus.
// Data stays a plain inout on the responder.
interface mem_bus_responder_if;
  logic nALE;
  logic nME;
  logic RnW;
  logic nOE;
  logic nDrive;
  logic BusErr;

  modport slave (
    input  nALE, nME, RnW, nOE,
    output nDrive, BusErr
  );

  modport master (
    output nALE, nME, RnW, nOE,
    input  nDrive, BusErr
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the multiplexed 64-bit bus.
// MEM_RANGE_CHECK_EN: flag and suppress out-of-range accesses.
module mem_bus_responder #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int ADDR_LSB   = 3
) (
  input  logic        Clock,
  input  logic        nReset,
  inout  wire  [63:0] Data,
  mem_bus_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RD,
    WR
  } state_t;

  localparam int AHI = ADDR_LSB + ADDR_WIDTH;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [63:0]             rd_data;
  logic [63:0]             mem [DEPTH];
  logic                    rd_en;
  logic                    wr_en;
  logic                    drive;
  logic                    oor;
  logic                    unused_bits;

  assign unused_bits = ^Data;

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    if (!bus.nALE) begin
      state_nx = ADDR;
    end else begin
      unique case (state)
        IDLE: state_nx = IDLE;
        ADDR: begin
          if (!bus.nME) begin
            if (bus.RnW) begin
              rd_en    = 1'b1;
              state_nx = RD;
            end else begin
              wr_en    = !oor;
              state_nx = WR;
            end
          end
        end
        RD, WR: begin
          if (bus.nME) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state    <= IDLE;
      addr_reg <= '0;
      rd_data  <= '0;
    end else begin
      state <= state_nx;
      if (!bus.nALE)
        addr_reg <= Data[AHI-1:ADDR_LSB];
      if (rd_en)
        rd_data <= oor ? 64'hDEAD_BEEF_DEAD_BEEF
                       : mem[addr_reg];
    end
  end

  // RAM is deliberately not reset; reset only blocks new writes.
  always_ff @(posedge Clock) begin
    if (nReset && wr_en)
      mem[addr_reg] <= Data;
  end

`ifdef MEM_RANGE_CHECK_EN
  always_ff @(posedge Clock) begin
    if (!nReset)
      oor <= 1'b0;
    else if (!bus.nALE)
      oor <= |Data[63:AHI];
  end

  assign bus.BusErr = oor && (state == RD || state == WR);
`else
  assign oor        = 1'b0;
  assign bus.BusErr = 1'b0;
`endif

  assign drive = (state == RD) && !bus.nME &&
                 !bus.nOE && bus.RnW;

  assign bus.nDrive = !drive;
  assign Data       = drive ? rd_data : 64'bz;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench with a transaction-level model of the responder.
// Honours MEM_RANGE_CHECK_EN the same way the design does.
module tb_mem_bus_responder;

  logic        Clock;
  logic        nReset;
  logic        tb_en;
  logic [63:0] tb_data;
  wire  [63:0] Data;

  int checks;
  int errors;

  mem_bus_responder_if bus ();

  assign Data = tb_en ? tb_data : 64'bz;

  mem_bus_responder dut (
    .Clock  (Clock),
    .nReset (nReset),
    .Data   (Data),
    .bus    (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Model: an address phase arms one access; the first
  // nME-low edge afterwards performs it exactly once.
  logic [63:0] m [int];
  bit          started;
  bit          armed;
  bit          rd_act;
  bit          wr_act;
  bit          bad;
  bit          data_known;
  int          idx;
  logic [63:0] exp_rd;

  always @(posedge Clock) begin
    started = 1'b1;
    if (!nReset) begin
      armed  = 0;
      rd_act = 0;
      wr_act = 0;
      bad    = 0;
      exp_rd = '0;
      data_known = 1;
    end else if (!bus.nALE) begin
      armed  = 1;
      rd_act = 0;
      wr_act = 0;
      idx    = int'((Data / 8) % 256);
`ifdef MEM_RANGE_CHECK_EN
      bad    = (Data >= 64'd2048);
`else
      bad    = 0;
`endif
    end else if (armed && !bus.nME) begin
      armed = 0;
      if (bus.RnW) begin
        rd_act = 1;
        if (bad) begin
          exp_rd = 64'hDEAD_BEEF_DEAD_BEEF;
          data_known = 1;
        end else if (m.exists(idx)) begin
          exp_rd = m[idx];
          data_known = 1;
        end else begin
          data_known = 0;
        end
      end else begin
        wr_act = 1;
        if (!bad) m[idx] = Data;
      end
    end else if ((rd_act || wr_act) && bus.nME) begin
      rd_act = 0;
      wr_act = 0;
    end
  end

  always @(negedge Clock) begin
    if (started) begin
      logic exp_drv;
      exp_drv = rd_act && !bus.nME && !bus.nOE && bus.RnW;
      chk("nDrive", 64'(bus.nDrive), 64'(!exp_drv));
      chk("BusErr", 64'(bus.BusErr),
          64'(bad && (rd_act || wr_act)));
      if (exp_drv && data_known)
        chk("Data", Data, exp_rd);
    end
  end

  task automatic tick;
    @(posedge Clock);
    #2;
  endtask

  task automatic idle;
    bus.nALE = 1;
    bus.nME  = 1;
    bus.RnW  = 1;
    bus.nOE  = 1;
    tb_en    = 0;
  endtask

  task automatic addr_phase(input logic [63:0] a);
    bus.nALE = 0;
    tb_en    = 1;
    tb_data  = a;
    tick();
    bus.nALE = 1;
    tb_en    = 0;
  endtask

  task automatic write(input logic [63:0] a,
                       input logic [63:0] d);
    addr_phase(a);
    bus.nME = 0;
    bus.RnW = 0;
    tb_en   = 1;
    tb_data = d;
    tick();
    idle();
    tick();
  endtask

  task automatic read_check(input string name,
                            input logic [63:0] a,
                            input logic [63:0] exp);
    addr_phase(a);
    bus.nME = 0;
    bus.RnW = 1;
    bus.nOE = 0;
    tick();
    @(negedge Clock);
    chk({name, "_drv"}, 64'(bus.nDrive), 64'd0);
    chk({name, "_data"}, Data, exp);
    bus.nOE = 1;
    #1;
    chk({name, "_rel"}, 64'(bus.nDrive), 64'd1);
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks  = 0;
    errors  = 0;
    tb_data = '0;
    nReset  = 0;
    idle();
    tick();
    tick();
    chk("rst_nDrive", 64'(bus.nDrive), 64'd1);
    chk("rst_BusErr", 64'(bus.BusErr), 64'd0);
    nReset = 1;
    tick();

    write(64'h40, 64'h0123_4567_89AB_CDEF);
    read_check("rd40", 64'h40, 64'h0123_4567_89AB_CDEF);

    // Held write: only the first data word lands.
    addr_phase(64'h08);
    bus.nME = 0;
    bus.RnW = 0;
    tb_en   = 1;
    for (int i = 1; i <= 4; i++) begin
      tb_data = 64'(i);
      tick();
    end
    idle();
    tick();
    read_check("rd08", 64'h08, 64'd1);

    // nME low in IDLE must not write.
    write(64'h0, 64'hA5A5_0000_1111_2222);
    bus.nME = 0;
    bus.RnW = 0;
    tb_en   = 1;
    tb_data = 64'hFF;
    tick();
    tick();
    idle();
    tick();
    read_check("rd00", 64'h0, 64'hA5A5_0000_1111_2222);

    // Re-address while a read is active.
    write(64'h10, 64'h2222);
    write(64'h18, 64'h3333);
    addr_phase(64'h10);
    bus.nME = 0;
    bus.RnW = 1;
    bus.nOE = 0;
    tick();
    @(negedge Clock);
    chk("abort_pre", Data, 64'h2222);
    bus.nOE  = 1;
    bus.nALE = 0;
    tb_en    = 1;
    tb_data  = 64'h18;
    tick();
    bus.nALE = 1;
    tb_en    = 0;
    bus.nOE  = 0;
    @(negedge Clock);
    chk("abort_gap", 64'(bus.nDrive), 64'd1);
    tick();
    @(negedge Clock);
    chk("abort_new", Data, 64'h3333);
    idle();
    tick();
    read_check("rd10", 64'h10, 64'h2222);

    // Reset mid-read releases the bus; RAM persists.
    addr_phase(64'h40);
    bus.nME = 0;
    bus.RnW = 1;
    bus.nOE = 0;
    tick();
    nReset = 0;
    tick();
    chk("rst_mid", 64'(bus.nDrive), 64'd1);
    nReset = 1;
    idle();
    tick();
    read_check("rd40b", 64'h40, 64'h0123_4567_89AB_CDEF);

    // Upper address bits: range error or wrap.
    write(64'h1_0000_0000, 64'h55);
`ifdef MEM_RANGE_CHECK_EN
    read_check("rdoor", 64'h1_0000_0000,
               64'hDEAD_BEEF_DEAD_BEEF);
    read_check("rd00w", 64'h0, 64'hA5A5_0000_1111_2222);
`else
    read_check("rd00w", 64'h0, 64'h55);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the core's multiplexed 64-bit external bus: Data, nME, nALE, RnW, nOE.
- Latches the address phase, then serves single-word reads and writes from an internal word-addressed RAM.
- Sits on the board/testbench side of each core's bus, one instance per core.
- Drives Data only during a qualified read data phase; Data is high-impedance at all other times.

Parameters:
- DEPTH, 256: number of 64-bit words; power of two.
- ADDR_WIDTH, 8: word-index width; must equal log2(DEPTH).
- ADDR_LSB, 3: lowest byte-address bit used as the word index. Bits [ADDR_LSB-1:0] are ignored.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- nReset  input  1  synchronous, active-low reset.
- Data  inout  64  multiplexed address/data bus.
- nALE  input  1  address latch enable, active low.
- nME  input  1  memory enable, active low.
- RnW  input  1  1 = read, 0 = write.
- nOE  input  1  output enable, active low.
- nDrive  output  1  0 while this block drives Data (observability).
- BusErr  output  1  out-of-range flag (see Optional Feature).

Behaviour:
- Clock/reset: one clock, Clock. Reset is synchronous active-low on nReset: sampled at the rising edge; async assertion has no effect.
- Reset values: state=IDLE, addr_reg=0, rd_data=0, nDrive=1, BusErr=0, Data=Z. RAM contents are not reset.
- States: IDLE, ADDR, RD, WR.
- nALE=0 at an edge, from any state (highest priority after reset):
  - addr_reg <= Data[ADDR_LSB+ADDR_WIDTH-1:ADDR_LSB]; state <= ADDR.
  - This aborts any RD/WR in progress without a memory side effect.
- ADDR, nME=0, RnW=1: rd_data <= mem[addr_reg]; state <= RD. Read latency is 1 clock from nME sampled low.
- ADDR, nME=0, RnW=0: mem[addr_reg] <= Data on that same edge; state <= WR. Exactly one write per address phase.
- ADDR, nME=1: hold ADDR.
- RD or WR, nME=1: state <= IDLE.
- RD or WR, nME=0: hold. No repeated write; rd_data is held.
- RnW changing during RD/WR: no state change. Drive stops immediately if RnW=0.
- IDLE, nME=0: ignored. No write, no drive.
- Drive condition (combinational): state==RD && nME==0 && nOE==0 && RnW==1.
  - nDrive = !drive.
  - Data = drive ? rd_data : 64'bz.
- nALE and nME both low at the same edge: the address is latched; the access is not started until the next edge.
- Reset mid-access: the state machine returns to IDLE at that edge, Data releases. A write already committed on an earlier edge persists.
- Address mapping: index = latched bits, i.e. modulo DEPTH.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- With the macro defined:
  - The address phase also checks Data[63:ADDR_LSB+ADDR_WIDTH]. Any nonzero bit marks the access out of range.
  - Out-of-range write: dropped (RAM unchanged).
  - Out-of-range read: rd_data <= 64'hDEAD_BEEF_DEAD_BEEF.
  - BusErr=1 in the RD/WR state of that access; cleared on leaving it or on reset.
- Without the macro: upper bits are ignored (wrap), and BusErr is tied 0.

Test Plan:
1. Reset with nReset=0 for 2 clocks, all other inputs idle -> Data=Z, nDrive=1, BusErr=0, state IDLE.
2. Address 0x40 with nALE low for 1 clock, then nME=0, RnW=0, Data=0x0123456789ABCDEF for 1 clock, then nME=1. Next: address 0x40, nME=0, RnW=1, nOE=0 -> Data=0x0123456789ABCDEF from the second edge after nME low; nDrive=0; released when nOE=1.
3. Hold nME=0, RnW=0 for 4 clocks after address 0x08 with changing Data (1,2,3,4) -> mem[1]=1 only; reading 0x08 returns 1.
4. nME=0, RnW=0 in IDLE with no prior nALE, Data=0xFF -> no write; a following read of address 0 returns the prior contents.
5. Read of 0x10 in RD state, then nALE pulse to 0x18 while nME=0 -> drive stops the cycle after, new access at word 3, no write to word 2.
6. MEM_RANGE_CHECK_EN defined, address 0x1_0000_0000:
   - Write 0x55 -> BusErr=1 during WR; word 0 unchanged.
   - Read of the same address -> Data=0xDEADBEEFDEADBEEF, BusErr=1.
   - Macro undefined: the same write lands in word 0.
